// File: rtl/icache_dm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : icache_dm_pkg
// Brief    : Shared bus structs, memory-request constants and the cache state
//            type for the direct-mapped instruction cache.
// Revision : 1.0
// ============================================================================
package icache_dm_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef logic [2:0] msize_t;
    typedef logic [7:0] mlen_t;
    typedef logic [1:0] axi_burst_t;

    localparam msize_t MSIZE1 = 3'd0;
    localparam msize_t MSIZE2 = 3'd1;
    localparam msize_t MSIZE4 = 3'd2;
    localparam msize_t MSIZE8 = 3'd3;

    // Burst length is encoded as beats minus one.
    localparam mlen_t MLEN1 = 8'd0;
    localparam mlen_t MLEN2 = 8'd1;

    localparam axi_burst_t AXI_BURST_FIXED = 2'd0;
    localparam axi_burst_t AXI_BURST_INCR  = 2'd1;
    localparam axi_burst_t AXI_BURST_WRAP  = 2'd2;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        msize_t      size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        mlen_t       len;
        axi_burst_t  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } icache_state_e;

endpackage
`default_nettype wire

// File: rtl/icache_ram.sv
`default_nettype none
// ============================================================================
// Module   : icache_ram
// Brief    : Line data array, two 64-bit words per line, per-word write
//            enable, asynchronous read.
// Revision : 1.0
// ============================================================================
module icache_ram #(
    parameter int LINES = 16,
    parameter int IDX_W = $clog2(LINES)
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] waddr,
    input  logic [1:0]       wen,
    input  logic [127:0]     wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [127:0]     rdata
);

    logic [127:0] r_mem [LINES];

    always_ff @(posedge clk) begin
        for (int w = 0; w < 2; w++) begin
            if (wen[w]) begin
                r_mem[waddr][w*64 +: 64] <= wdata[w*64 +: 64];
            end
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/icache_dm.sv
`default_nettype none
// ============================================================================
// Module   : icache_dm
// Brief    : Direct-mapped, read-only instruction cache; same-cycle hits and a
//            two-beat INCR refill on a miss.
// Revision : 1.0
// ============================================================================
module icache_dm
    import icache_dm_pkg::*;
#(
    parameter int LINES      = 16,
    parameter int LINE_BYTES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    output cbus_req_t  creq,
    input  cbus_resp_t cresp
);

    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 64 - OFF_W - IDX_W;

    icache_state_e    r_state;
    icache_state_e    w_next;
    logic             r_cnt;
    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag [LINES];
    logic [63:0]      r_addr;

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic [IDX_W-1:0] w_fill_idx;
    logic [TAG_W-1:0] w_fill_tag;
    logic [127:0]     w_line;
    logic [63:0]      w_word;
    logic [31:0]      w_half;
    logic             w_hit;
    logic             w_beat;
    logic             w_done;
    logic [1:0]       w_wen;
    logic             w_unused;

    assign w_idx      = ireq.addr[OFF_W +: IDX_W];
    assign w_tag      = ireq.addr[63 -: TAG_W];
    assign w_fill_idx = r_addr[OFF_W +: IDX_W];
    assign w_fill_tag = r_addr[63 -: TAG_W];
    assign w_unused   = ^ireq.addr[1:0];

    assign w_word = ireq.addr[3] ? w_line[127:64] : w_line[63:0];
    assign w_half = ireq.addr[2] ? w_word[63:32]  : w_word[31:0];
    assign w_hit  = ireq.valid && r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    assign w_beat = (r_state == REFILL) && cresp.ready;
    assign w_done = w_beat && cresp.last;
    assign w_wen  = w_beat ? (2'b01 << r_cnt) : 2'b00;

    icache_ram #(
        .LINES (LINES),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk   (clk),
        .waddr (w_fill_idx),
        .wen   (w_wen),
        .wdata ({cresp.data, cresp.data}),
        .raddr (w_idx),
        .rdata (w_line)
    );

    always_comb begin
        w_next = r_state;
        iresp  = '0;
        creq   = '0;
        case (r_state)
            IDLE: begin
                if (w_hit) begin
                    iresp.addr_ok = 1'b1;
                    iresp.data_ok = 1'b1;
                    iresp.data    = w_half;
                end else if (ireq.valid) begin
                    w_next = REFILL;
                end
            end
            REFILL: begin
                creq.valid = 1'b1;
                creq.size  = MSIZE8;
                creq.len   = MLEN2;
                creq.burst = AXI_BURST_INCR;
                creq.addr  = r_addr;
                if (w_done) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 1'b0;
            r_valid <= '0;
            r_addr  <= '0;
        end else begin
            r_state <= w_next;
            // The target line is invalidated before its first beat lands so a
            // half-overwritten line can never hit.
            if ((r_state == IDLE) && (w_next == REFILL)) begin
                r_addr         <= {ireq.addr[63:OFF_W], {OFF_W{1'b0}}};
                r_valid[w_idx] <= 1'b0;
            end
            if (w_beat) begin
                r_cnt <= w_done ? 1'b0 : r_cnt + 1'b1;
            end
            if (w_done) begin
                r_valid[w_fill_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_done) begin
            r_tag[w_fill_idx] <= w_fill_tag;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache_dm.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_dm
// Brief    : Directed, table-driven bench for icache_dm with a beat-level
//            memory model and hand-written refill corner sequences.
// Revision : 1.0
// ============================================================================
module tb_icache_dm;
    import icache_dm_pkg::*;

    logic       clk;
    logic       reset;
    ibus_req_t  ireq;
    ibus_resp_t iresp;
    cbus_req_t  creq;
    cbus_resp_t cresp;

    int n_cmp  = 0;
    int n_fail = 0;
    int mem_beat  = 0;
    int mem_wcnt  = 0;
    int mem_waits = 0;

    icache_dm #(
        .LINES      (16),
        .LINE_BYTES (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ireq  (ireq),
        .iresp (iresp),
        .creq  (creq),
        .cresp (cresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        int          waits;
        bit          miss;
        logic [31:0] data;
        int          cycles;
    } vec_t;

    vec_t vecs [11];

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        if (a == 64'h8000_0000)      return 64'h0000_0013_0000_0093;
        else if (a == 64'h8000_0008) return 64'h0000_0113_0000_0193;
        else                         return {~a[31:0], a[31:0]};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic mem_drive();
        cresp = '0;
        if (creq.valid) begin
            if (mem_wcnt >= mem_waits) begin
                cresp.ready = 1'b1;
                cresp.last  = (mem_beat == 1);
                cresp.data  = mem_word(creq.addr + 64'(mem_beat * 8));
            end
        end
    endtask

    task automatic mem_advance();
        if (cresp.ready) begin
            mem_beat = cresp.last ? 0 : mem_beat + 1;
            mem_wcnt = 0;
        end else if (creq.valid) begin
            mem_wcnt++;
        end
    endtask

    // Presents one fetch (entered just after a falling edge) and follows it to data_ok.
    task automatic run_fetch(input string nm, input logic [63:0] a, input int waits,
                             input bit miss, input logic [31:0] exp_d, input int exp_c);
        int          cyc;
        bit          done;
        bit          saw;
        bit          fields_ok;
        bit          aok;
        logic [31:0] got;
        mem_waits  = waits;
        ireq.valid = 1'b1;
        ireq.addr  = a;
        done = 0; saw = 0; fields_ok = 1; aok = 0; got = '0; cyc = 0;
        for (int i = 1; i <= 100 && !done; i++) begin
            mem_drive();
            #1;
            if (creq.valid) begin
                saw = 1;
                if (creq.addr !== {a[63:4], 4'b0} || creq.len !== MLEN2 ||
                    creq.size !== MSIZE8 || creq.burst !== AXI_BURST_INCR ||
                    creq.is_write !== 1'b0 || creq.strobe !== 8'h00)
                    fields_ok = 0;
            end
            if (iresp.data_ok) begin
                done = 1; cyc = i; got = iresp.data; aok = iresp.addr_ok;
            end
            mem_advance();
            if (!done) @(negedge clk);
        end
        check($sformatf("%s.done", nm), 64'(done), 64'd1);
        check($sformatf("%s.data", nm), 64'(got), 64'(exp_d));
        check($sformatf("%s.cycles", nm), 64'(cyc), 64'(exp_c));
        check($sformatf("%s.addr_ok", nm), 64'(aok), 64'd1);
        check($sformatf("%s.refill_seen", nm), 64'(saw), 64'(miss));
        check($sformatf("%s.creq_fields", nm), 64'(fields_ok), 64'd1);
        ireq.valid = 1'b0;
        cresp      = '0;
        @(negedge clk);
    endtask

    initial begin
        bit held_ok;

        vecs[0]  = '{64'h8000_0000, 0, 1'b1, 32'h0000_0093, 4};
        vecs[1]  = '{64'h8000_0004, 0, 1'b0, 32'h0000_0013, 1};
        vecs[2]  = '{64'h8000_0008, 0, 1'b0, 32'h0000_0193, 1};
        vecs[3]  = '{64'h8000_000C, 0, 1'b0, 32'h0000_0113, 1};
        vecs[4]  = '{64'h8000_0100, 0, 1'b1, 32'h8000_0100, 4};
        vecs[5]  = '{64'h8000_010C, 0, 1'b0, 32'h7FFF_FEF7, 1};
        vecs[6]  = '{64'h8000_0000, 0, 1'b1, 32'h0000_0093, 4};
        vecs[7]  = '{64'h8000_0020, 3, 1'b1, 32'h8000_0020, 10};
        vecs[8]  = '{64'h8000_0028, 0, 1'b0, 32'h8000_0028, 1};
        vecs[9]  = '{64'h8000_002C, 0, 1'b0, 32'h7FFF_FFD7, 1};
        vecs[10] = '{64'h8000_00F4, 0, 1'b1, 32'h7FFF_FF0F, 4};

        reset      = 1'b1;
        ireq.valid = 1'b1;
        ireq.addr  = 64'h8000_0000;
        cresp      = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset.iresp", {30'b0, iresp}, 64'd0);
        check("reset.creq_valid", 64'(creq.valid), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int v = 0; v < 11; v++) begin
            run_fetch($sformatf("vec%0d", v), vecs[v].addr, vecs[v].waits,
                      vecs[v].miss, vecs[v].data, vecs[v].cycles);
        end

        // Fetch redirected to an already valid line while line 1 refills.
        mem_waits  = 0;
        held_ok    = 1;
        ireq.valid = 1'b1;
        ireq.addr  = 64'h8000_0010;
        for (int i = 0; i < 3; i++) begin
            mem_drive();
            if (i == 1) ireq.addr = 64'h8000_0000;
            #1;
            if (iresp.data_ok !== 1'b0) held_ok = 0;
            mem_advance();
            @(negedge clk);
        end
        cresp = '0;
        #1;
        check("redirect.no_data_ok_during_refill", 64'(held_ok), 64'd1);
        check("redirect.hit", 64'(iresp.data_ok), 64'd1);
        check("redirect.data", 64'(iresp.data), 64'h0000_0093);
        check("redirect.creq_idle", 64'(creq.valid), 64'd0);
        ireq.valid = 1'b0;
        @(negedge clk);
        run_fetch("line1_valid", 64'h8000_0010, 0, 1'b0, 32'h8000_0010, 1);

        // Reset lands after the first beat of a refill.
        mem_waits  = 0;
        ireq.valid = 1'b1;
        ireq.addr  = 64'h8000_0030;
        for (int i = 0; i < 2; i++) begin
            mem_drive();
            #1;
            mem_advance();
            @(negedge clk);
        end
        mem_drive();
        #1;
        check("abort.creq_before_reset", 64'(creq.valid), 64'd1);
        reset = 1'b1;
        #1;
        check("abort.creq_valid", 64'(creq.valid), 64'd0);
        check("abort.iresp", {30'b0, iresp}, 64'd0);
        cresp    = '0;
        mem_beat = 0;
        mem_wcnt = 0;
        @(negedge clk);
        reset = 1'b0;
        run_fetch("after_abort", 64'h8000_0030, 0, 1'b1, 32'h8000_0030, 4);
        run_fetch("after_abort_cold", 64'h8000_0000, 0, 1'b1, 32'h0000_0093, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
